// File: rtl/add_serial_16bit_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM states, widths, saturation values.
package add_serial_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned NIB_W     = 4;

    localparam logic [WIDTH_DEF-1:0] SAT_POS = 16'h7FFF;
    localparam logic [WIDTH_DEF-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_serial_16bit_if.sv
// Request/result bundle of the nibble-serial adder; master issues operands, slave returns the result.
interface add_serial_16bit_if
    import add_serial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovfl;
    logic             neg;
    logic             zero;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovfl, neg, zero
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovfl, neg, zero
    );
endinterface

// File: rtl/add_serial_16bit_adder_4bit.sv
// Combinational 4-bit adder used as the per-nibble slice of the serial adder.
module adder_4bit
    import add_serial_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = (NIB_W+1)'(a) + (NIB_W+1)'(b) + (NIB_W+1)'(cin);
endmodule

// File: rtl/add_serial_16bit.sv
// Nibble-serial two's-complement adder: one 4-bit slice per cycle, LSB first, result with N/Z/V flags.
// Optional ADD_SERIAL_SAT_EN saturates the presented sum on signed overflow.
module add_serial_16bit
    import add_serial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    add_serial_16bit_if.slave   bus
);
    localparam int unsigned NNIB  = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   res;

    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovfl_q;
    logic               neg_q;
    logic               zero_q;

    logic [NIB_W-1:0]   nib_sum;
    logic               nib_cout;
    logic [WIDTH-1:0]   final_c;
    logic               raw_ovfl_c;
    logic [WIDTH-1:0]   pres_c;

    // Operand registers shift right so the active nibble always sits in bits [3:0].
    adder_4bit u_nib_adder (
        .a    (op_a[NIB_W-1:0]),
        .b    (op_b[NIB_W-1:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign final_c = {nib_sum, res[WIDTH-1:NIB_W]};

    // On the last nibble op_a[3]/op_b[3] hold the original operand sign bits.
    assign raw_ovfl_c = (op_a[NIB_W-1] == op_b[NIB_W-1]) && (nib_sum[NIB_W-1] != op_a[NIB_W-1]);

`ifdef ADD_SERIAL_SAT_EN
    localparam logic [WIDTH-1:0] SAT_P = (WIDTH == WIDTH_DEF) ? WIDTH'(SAT_POS) : {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_N = (WIDTH == WIDTH_DEF) ? WIDTH'(SAT_NEG) : {1'b1, {(WIDTH-1){1'b0}}};
    assign pres_c = raw_ovfl_c ? (op_a[NIB_W-1] ? SAT_N : SAT_P) : final_c;
`else
    assign pres_c = final_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovfl_q <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.b;
                        carry  <= bus.cin;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    res   <= final_c;
                    op_a  <= {NIB_W'(0), op_a[WIDTH-1:NIB_W]};
                    op_b  <= {NIB_W'(0), op_b[WIDTH-1:NIB_W]};
                    carry <= nib_cout;
                    idx   <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NNIB - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        sum_q  <= pres_c;
                        cout_q <= nib_cout;
                        ovfl_q <= raw_ovfl_c;
                        neg_q  <= pres_c[WIDTH-1];
                        zero_q <= (pres_c == '0);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovfl = ovfl_q;
    assign bus.neg  = neg_q;
    assign bus.zero = zero_q;

endmodule

// File: doc/add_serial_16bit.md
# add_serial_16bit

Multi-cycle, nibble-serial 16-bit two's-complement adder for the datapath's add direction. It complements the combinational 4-bit subtract path. Operands are latched on a start request and summed one 4-bit slice per cycle, LSB nibble first, through a single 4-bit adder. The block then presents the sum, carry-out and N/Z/V flags with a one-cycle done pulse. Used where ALU area matters more than latency, e.g. address/PC offset accumulation.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4; nibble count NNIB = WIDTH/4.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only in IDLE or DONE.
- a  in  WIDTH  operand A, sampled on the accepting edge.
- b  in  WIDTH  operand B, sampled on the accepting edge.
- cin  in  1  carry-in to nibble 0, sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result outputs valid from this cycle.
- sum  out  WIDTH  result; holds last completed value until the next completion.
- cout  out  1  raw carry out of MSB nibble (never saturated).
- ovfl  out  1  signed overflow: a[MSB]==b[MSB] and raw sum[MSB]!=a[MSB].
- neg  out  1  sum[MSB] of the presented (final) sum.
- zero  out  1  presented sum == 0.

## Operation
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE: start=1 → latch a, b, cin; nibble index ← 0; carry ← cin; go to RUN.
- RUN: add nibble[idx] of A and B with the carry register; write the 4-bit result into the internal result shift register; carry ← nibble carry-out; idx ← idx+1. After idx = NNIB-1, go to DONE.
- DONE: load sum/cout/ovfl/neg/zero from the internal result; done=1.
  - If start=1, accept new operands and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- start in RUN is ignored; it is neither queued nor latched. Operand changes during RUN have no effect.
- Overflow uses the latched operand sign bits and the raw sum MSB. cin participates in all arithmetic.
- Reset (any state, including mid-RUN):
  - State goes to IDLE, idx to 0, carry to 0.
  - busy=0, done=0, sum=0, cout=0, ovfl=0, neg=0, zero=0.
  - No done pulse follows for an aborted operation.

## Timing
- start accepted at edge T. RUN occupies cycles T+1 … T+NNIB, which is T+1…T+4 for WIDTH=16.
- DONE occupies cycle T+NNIB+1, which is T+5. done and all result outputs are valid in that cycle.
- Latency from start to done is NNIB+1 cycles.
- Back-to-back throughput is one result per NNIB+1 cycles.
- busy is high exactly during RUN cycles. done is never high for two consecutive cycles.
- Outputs are registered; no combinational path from a, b, cin or start to any output.

## Configuration
- ADD_SERIAL_SAT_EN defined: on ovfl=1, sum is saturated.
  - Positive overflow (a[MSB]=0) gives 0x7FFF.
  - Negative overflow (a[MSB]=1) gives 0x8000.
  - neg and zero are computed from the saturated value.
  - ovfl and cout still report raw conditions.
- Not defined: sum is the wrap-around result. ovfl is still reported.

## Structure
- Package add_serial_pkg holds:
  - state encodings IDLE/RUN/DONE;
  - default WIDTH and NIB_W=4;
  - saturation constants SAT_POS (0x7FFF) and SAT_NEG (0x8000).
- One sub-module: the existing adder_4bit, instantiated once as the per-nibble adder.
- Index counter, operand/result shift registers, FSM and flag logic live in the top module.

## Test plan
- a=0x1234, b=0x4321, cin=0, start at T → busy T+1..T+4; done at T+5; sum=0x5555, cout=0, ovfl=0, zero=0, neg=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovfl=0, zero=1; a=0x00FF, b=0x0000, cin=1 → sum=0x0100, carry propagated across the nibble boundary.
- a=0x7FFF, b=0x0001 → ovfl=1, cout=0. With ADD_SERIAL_SAT_EN: sum=0x7FFF, neg=0. Without: sum=0x8000, neg=1. a=0x8000, b=0xFFFF → ovfl=1, cout=1; with SAT sum=0x8000, without sum=0x7FFF.
- start held high continuously with new operands each DONE cycle → done pulses every 5 cycles, each result matches its own operands; start pulses during RUN are ignored.
- start at T, rst=1 at T+2 for one cycle → all outputs 0 at T+3, no done pulse; a new start at T+4 completes normally at T+9.
